// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S target.
//   i2s_target_state_t    : slot-tracking state (SYNC, LEFT, RIGHT)
//   I2S_DEFAULT_BIT_DEPTH : default sample width per channel
package i2s_pkg;

  localparam int unsigned I2S_DEFAULT_BIT_DEPTH = 24;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } i2s_target_state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with an optional
// edge register that produces single-cycle rise/fall events.
//   clk, rst_n  : system clock, async active-low reset
//   d_in        : asynchronous input
//   d_sync      : synchronized level
//   rise, fall  : one-cycle edge events (tied low when EDGE_DETECT = 0)
module i2s_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EDGE_DETECT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic d_sync,
  output logic rise,
  output logic fall
);

  // Fewer than two stages would not give metastability protection.
  localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign d_sync = sync_q[STAGES-1];

  if (EDGE_DETECT) begin : g_edge
    logic edge_q, edge_d;

    always_comb edge_d = d_sync;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) edge_q <= 1'b0;
      else        edge_q <= edge_d;
    end

    assign rise = d_sync & ~edge_q;
    assign fall = ~d_sync & edge_q;
  end else begin : g_no_edge
    assign rise = 1'b0;
    assign fall = 1'b0;
  end

endmodule

// File: rtl/i2s_target.sv
// I2S target (bit clock and word select supplied by the codec), running
// entirely in the mclk domain with bclk/lrclk/sd oversampled as data.
//   mclk, rst_n            : system clock, async active-low reset
//   bclk_in, lrclk_in      : external bit clock / word select (0=left)
//   sd_in, sd_out          : serial data from ADC / to DAC
//   rx_left/right/valid    : received frame, held until rx_ready
//   tx_left/right/valid    : frame to send, accepted when tx_ready
//   rx_overflow            : pulse when a frame is dropped (rx not drained)
//   tx_underflow           : pulse when a frame starts with no tx data
module i2s_target
  import i2s_pkg::*;
#(
  parameter int unsigned BIT_DEPTH   = I2S_DEFAULT_BIT_DEPTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 mclk,
  input  logic                 rst_n,
  input  logic                 bclk_in,
  input  logic                 lrclk_in,
  input  logic                 sd_in,
  output logic                 sd_out,
  output logic [BIT_DEPTH-1:0] rx_left,
  output logic [BIT_DEPTH-1:0] rx_right,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  input  logic [BIT_DEPTH-1:0] tx_left,
  input  logic [BIT_DEPTH-1:0] tx_right,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 rx_overflow,
  output logic                 tx_underflow
);

  localparam int unsigned CW = $clog2(BIT_DEPTH + 1);

  logic bclk_rise, bclk_fall, lr_s, sd_s;
  logic bclk_lvl_unused, lr_rise_unused, lr_fall_unused, sd_rise_unused, sd_fall_unused;

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DETECT(1'b1)) u_bclk (
    .clk(mclk), .rst_n(rst_n), .d_in(bclk_in),
    .d_sync(bclk_lvl_unused), .rise(bclk_rise), .fall(bclk_fall)
  );
  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DETECT(1'b0)) u_lrclk (
    .clk(mclk), .rst_n(rst_n), .d_in(lrclk_in),
    .d_sync(lr_s), .rise(lr_rise_unused), .fall(lr_fall_unused)
  );
  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DETECT(1'b0)) u_sd (
    .clk(mclk), .rst_n(rst_n), .d_in(sd_in),
    .d_sync(sd_s), .rise(sd_rise_unused), .fall(sd_fall_unused)
  );

  i2s_target_state_t    state_q, state_d;
  logic                 lr_prev_q, lr_prev_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BIT_DEPTH-1:0] rx_word_q, rx_word_d, word_done;
  logic [BIT_DEPTH-1:0] left_stage_q, left_stage_d;
  logic                 left_ok_q, left_ok_d;
  logic [BIT_DEPTH-1:0] rx_left_q, rx_left_d, rx_right_q, rx_right_d;
  logic                 rx_valid_q, rx_valid_d, rx_overflow_q, rx_overflow_d;
  logic                 hold_full_q, hold_full_d, tx_underflow_q, tx_underflow_d;
  logic [BIT_DEPTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [BIT_DEPTH-1:0] shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic                 sd_out_q, sd_out_d, alive_q, alive_d, tx_bit;
  logic                 lr_fall_ev, lr_rise_ev;

  assign lr_fall_ev = bclk_rise &  lr_prev_q & ~lr_s;
  assign lr_rise_ev = bclk_rise & ~lr_prev_q &  lr_s;

  assign tx_ready     = alive_q & ~hold_full_q;
  assign sd_out       = sd_out_q;
  assign rx_left      = rx_left_q;
  assign rx_right     = rx_right_q;
  assign rx_valid     = rx_valid_q;
  assign rx_overflow  = rx_overflow_q;
  assign tx_underflow = tx_underflow_q;

  always_comb begin
    state_d = state_q;
    if (lr_fall_ev)                              state_d = ST_LEFT;
    else if (lr_rise_ev && state_q != ST_RIGHT)  state_d = ST_RIGHT;
  end

  always_comb begin
    lr_prev_d      = lr_prev_q;
    cnt_d          = cnt_q;
    rx_word_d      = rx_word_q;
    left_stage_d   = left_stage_q;
    left_ok_d      = left_ok_q;
    rx_left_d      = rx_left_q;
    rx_right_d     = rx_right_q;
    rx_valid_d     = rx_valid_q;
    rx_overflow_d  = 1'b0;
    tx_underflow_d = 1'b0;
    hold_full_d    = hold_full_q;
    hold_l_d       = hold_l_q;
    hold_r_d       = hold_r_q;
    shift_l_d      = shift_l_q;
    shift_r_d      = shift_r_q;
    sd_out_d       = sd_out_q;
    alive_d        = 1'b1;
    tx_bit         = 1'b0;

    // Current slot word including the bit arriving on this rise; the bit on
    // a change-detecting rise still belongs to the slot that is ending.
    word_done = rx_word_q;
    for (int unsigned i = 0; i < BIT_DEPTH; i++)
      if (cnt_q == CW'(i)) word_done[BIT_DEPTH-1-i] = sd_s;

    if (bclk_rise) begin
      lr_prev_d = lr_s;
      if (lr_fall_ev || lr_rise_ev) begin
        cnt_d     = '0;
        rx_word_d = '0;
      end else begin
        rx_word_d = word_done;
        if (cnt_q < CW'(BIT_DEPTH)) cnt_d = cnt_q + CW'(1);
      end
    end

    if (lr_rise_ev && state_q == ST_LEFT) begin
      left_stage_d = word_done;
      left_ok_d    = 1'b1;
    end

    // Acceptance is applied before a commit so a same-cycle commit reloads.
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (lr_fall_ev && state_q == ST_RIGHT && left_ok_q) begin
      if (rx_valid_q && !rx_ready) begin
        rx_overflow_d = 1'b1;
      end else begin
        rx_left_d  = left_stage_q;
        rx_right_d = word_done;
        rx_valid_d = 1'b1;
      end
    end

    // Transfer to the shifter happens before a same-cycle load of holding.
    if (lr_fall_ev) begin
      if (hold_full_q) begin
        shift_l_d = hold_l_q;
        shift_r_d = hold_r_q;
      end else begin
        shift_l_d      = '0;
        shift_r_d      = '0;
        tx_underflow_d = 1'b1;
      end
      hold_full_d = 1'b0;
    end
    if (tx_valid && tx_ready) begin
      hold_l_d    = tx_left;
      hold_r_d    = tx_right;
      hold_full_d = 1'b1;
    end

    // The receive counter doubles as the transmit bit index: between the
    // change rise and the next rise it reads 0, so each fall shows bit n.
    for (int unsigned i = 0; i < BIT_DEPTH; i++)
      if (cnt_q == CW'(i))
        tx_bit = (state_q == ST_LEFT) ? shift_l_q[BIT_DEPTH-1-i] : shift_r_q[BIT_DEPTH-1-i];
    if (state_q == ST_SYNC) sd_out_d = 1'b0;
    else if (bclk_fall)     sd_out_d = tx_bit;
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_SYNC;
      lr_prev_q      <= 1'b0;
      cnt_q          <= '0;
      rx_word_q      <= '0;
      left_stage_q   <= '0;
      left_ok_q      <= 1'b0;
      rx_left_q      <= '0;
      rx_right_q     <= '0;
      rx_valid_q     <= 1'b0;
      rx_overflow_q  <= 1'b0;
      tx_underflow_q <= 1'b0;
      hold_full_q    <= 1'b0;
      hold_l_q       <= '0;
      hold_r_q       <= '0;
      shift_l_q      <= '0;
      shift_r_q      <= '0;
      sd_out_q       <= 1'b0;
      alive_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      lr_prev_q      <= lr_prev_d;
      cnt_q          <= cnt_d;
      rx_word_q      <= rx_word_d;
      left_stage_q   <= left_stage_d;
      left_ok_q      <= left_ok_d;
      rx_left_q      <= rx_left_d;
      rx_right_q     <= rx_right_d;
      rx_valid_q     <= rx_valid_d;
      rx_overflow_q  <= rx_overflow_d;
      tx_underflow_q <= tx_underflow_d;
      hold_full_q    <= hold_full_d;
      hold_l_q       <= hold_l_d;
      hold_r_q       <= hold_r_d;
      shift_l_q      <= shift_l_d;
      shift_r_q      <= shift_r_d;
      sd_out_q       <= sd_out_d;
      alive_q        <= alive_d;
    end
  end

endmodule
